// File: rtl/timer_bus_master.sv
// Host-side initiator for the 8253-style TIMER write bus:
// programs control+count, then waits for the first `out` rising edge.
module timer_bus_master #(
  parameter int STROBE_CYCLES = 1,
  parameter int TIMEOUT       = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_ctrl,
  input  logic [15:0] req_count,
  input  logic        req_wait,
  output logic [15:0] data,
  output logic        cs,
  output logic        wr,
  output logic        a0,
  input  logic        timer_out,
  output logic        done_valid,
  output logic        done_timeout,
  output logic [15:0] done_cycles,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, C_SETUP, C_STROBE, C_HOLD,
    N_SETUP, N_STROBE, N_HOLD, WAIT, DONE
  } state_e;

  localparam logic [3:0]  SLAST = 4'(STROBE_CYCLES - 1);
  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] TFULL = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] ctrl_q, ctrl_d;
  logic [15:0] count_q, count_d;
  logic        wait_q, wait_d;
  logic [3:0]  scnt_q, scnt_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        to_q, to_d;
  logic [15:0] cyc_q, cyc_d;
  logic        sync1_q, sync2_q, prev_q;
  logic        rise;

  logic [15:0] data_q, data_d;
  logic        cs_q, cs_d;
  logic        wr_q, wr_d;
  logic        a0_q, a0_d;
  logic        ready_q, dv_q, busy_q;
  logic        ctl_st, cnt_st;

  assign rise = sync2_q & ~prev_q;

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    count_d = count_q;
    wait_d  = wait_q;
    scnt_d  = scnt_q;
    wcnt_d  = wcnt_q;
    to_d    = to_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          ctrl_d  = req_ctrl;
          count_d = req_count;
          wait_d  = req_wait;
          state_d = C_SETUP;
        end
      end
      C_SETUP: begin
        scnt_d  = '0;
        state_d = C_STROBE;
      end
      C_STROBE: begin
        if (scnt_q == SLAST) state_d = C_HOLD;
        else scnt_d = scnt_q + 4'd1;
      end
      C_HOLD: state_d = N_SETUP;
      N_SETUP: begin
        scnt_d  = '0;
        state_d = N_STROBE;
      end
      N_STROBE: begin
        if (scnt_q == SLAST) state_d = N_HOLD;
        else scnt_d = scnt_q + 4'd1;
      end
      N_HOLD: begin
        wcnt_d = '0;
        if (wait_q) begin
          state_d = WAIT;
        end else begin
          state_d = DONE;
          to_d    = 1'b0;
          cyc_d   = '0;
        end
      end
      WAIT: begin
        // an edge beats a coincident timeout
        if (rise) begin
          state_d = DONE;
          to_d    = 1'b0;
          cyc_d   = wcnt_q;
        end else if (wcnt_q == TLAST) begin
          state_d = DONE;
          to_d    = 1'b1;
          cyc_d   = TFULL;
        end else if (wcnt_q != 16'hFFFF) begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ctl_st = state_d inside {C_SETUP, C_STROBE, C_HOLD};
  assign cnt_st = state_d inside {N_SETUP, N_STROBE, N_HOLD};

  always_comb begin
    cs_d   = 1'b0;
    a0_d   = 1'b0;
    data_d = '0;
    wr_d   = state_d inside {C_STROBE, N_STROBE};
    unique case (1'b1)
      ctl_st: begin
        cs_d   = 1'b1;
        a0_d   = 1'b1;
        data_d = ctrl_d;
      end
      cnt_st: begin
        cs_d   = 1'b1;
        data_d = count_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      count_q <= '0;
      wait_q  <= 1'b0;
      scnt_q  <= '0;
      wcnt_q  <= '0;
      to_q    <= 1'b0;
      cyc_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      data_q  <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      a0_q    <= 1'b0;
      ready_q <= 1'b1;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      wait_q  <= wait_d;
      scnt_q  <= scnt_d;
      wcnt_q  <= wcnt_d;
      to_q    <= to_d;
      cyc_q   <= cyc_d;
      sync1_q <= timer_out;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      data_q  <= data_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      a0_q    <= a0_d;
      ready_q <= (state_d == IDLE);
      dv_q    <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign data         = data_q;
  assign cs           = cs_q;
  assign wr           = wr_q;
  assign a0           = a0_q;
  assign req_ready    = ready_q;
  assign done_valid   = dv_q;
  assign done_timeout = to_q;
  assign done_cycles  = cyc_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_timer_bus_master.sv
// Bench for timer_bus_master: two instances (strobe 1 and 3),
// an offset-based reference model, and directed literal checks.
module tb_timer_bus_master;

  localparam int TO = 50;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] req_valid, req_wait, timer_out;
  logic [1:0][15:0] req_ctrl, req_count;
  logic [1:0] req_ready, cs, wr, a0;
  logic [1:0] done_valid, done_timeout, busy;
  logic [1:0][15:0] data, done_cycles;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  timer_bus_master #(.STROBE_CYCLES(1), .TIMEOUT(TO)) u_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_ctrl(req_ctrl[0]), .req_count(req_count[0]),
    .req_wait(req_wait[0]), .data(data[0]),
    .cs(cs[0]), .wr(wr[0]), .a0(a0[0]),
    .timer_out(timer_out[0]),
    .done_valid(done_valid[0]),
    .done_timeout(done_timeout[0]),
    .done_cycles(done_cycles[0]), .busy(busy[0])
  );

  timer_bus_master #(.STROBE_CYCLES(3), .TIMEOUT(TO)) u_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_ctrl(req_ctrl[1]), .req_count(req_count[1]),
    .req_wait(req_wait[1]), .data(data[1]),
    .cs(cs[1]), .wr(wr[1]), .a0(a0[1]),
    .timer_out(timer_out[1]),
    .done_valid(done_valid[1]),
    .done_timeout(done_timeout[1]),
    .done_cycles(done_cycles[1]), .busy(busy[1])
  );

  function automatic int s_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h @%0t",
               nm, i, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 writing (k = cycles since accept),
  // 2 waiting (c = cycles into wait), 3 done pulse.
  int          ph[2];
  int          kk[2];
  int          cc[2];
  bit [15:0]   mctrl[2], mcount[2];
  bit          mwait[2];
  bit [3:0]    hist[2];
  bit          e_to[2];
  bit [15:0]   e_cyc[2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        ph[i] = 0; hist[i] = '0;
        e_to[i] = 1'b0; e_cyc[i] = '0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        hist[i] = {hist[i][2:0], timer_out[i]};
        case (ph[i])
          0: if (req_valid[i]) begin
            mctrl[i] = req_ctrl[i];
            mcount[i] = req_count[i];
            mwait[i] = req_wait[i];
            ph[i] = 1; kk[i] = 1;
          end
          1: if (kk[i] == 2 * s_of(i) + 4) begin
            if (mwait[i]) begin
              ph[i] = 2; cc[i] = 0;
            end else begin
              ph[i] = 3; e_to[i] = 1'b0; e_cyc[i] = '0;
            end
          end else kk[i]++;
          2: begin
            // pin seen 2 cycles late; edge = 1 now, 0 one earlier
            if (hist[i][2] && !hist[i][3]) begin
              ph[i] = 3; e_to[i] = 1'b0; e_cyc[i] = 16'(cc[i]);
            end else if (cc[i] == TO - 1) begin
              ph[i] = 3; e_to[i] = 1'b1; e_cyc[i] = 16'(TO);
            end else cc[i]++;
          end
          default: ph[i] = 0;
        endcase
      end
    end
  end

  bit        pwr[2];
  bit        pa0[2];
  bit [15:0] pdat[2];
  int        run[2];
  int        acc_n = 0;
  int        acc_t[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int s, j;
      logic cse, wre, a0e;
      logic [15:0] de;
      s = s_of(i);
      cse = 1'b0; wre = 1'b0; a0e = 1'b0; de = '0; j = 0;
      if (ph[i] == 1) begin
        cse = 1'b1;
        a0e = (kk[i] <= s + 2);
        j = a0e ? kk[i] : kk[i] - (s + 2);
        wre = (j >= 2 && j <= s + 1);
        de = a0e ? mctrl[i] : mcount[i];
      end
      chk("cs", i, {15'b0, cs[i]}, {15'b0, cse});
      chk("wr", i, {15'b0, wr[i]}, {15'b0, wre});
      chk("a0", i, {15'b0, a0[i]}, {15'b0, a0e});
      chk("data", i, data[i], de);
      chk("req_ready", i, {15'b0, req_ready[i]},
          {15'b0, ph[i] == 0});
      chk("busy", i, {15'b0, busy[i]}, {15'b0, ph[i] != 0});
      chk("done_valid", i, {15'b0, done_valid[i]},
          {15'b0, ph[i] == 3});
      if (ph[i] == 3) begin
        chk("done_timeout", i, {15'b0, done_timeout[i]},
            {15'b0, e_to[i]});
        chk("done_cycles", i, done_cycles[i], e_cyc[i]);
      end
      if (!reset) begin
        pwr[i] = 1'b0; run[i] = 0;
      end else begin
        if (wr[i]) begin
          if (pwr[i]) begin
            chk("a0_stable", i, {15'b0, a0[i]}, {15'b0, pa0[i]});
            chk("data_stable", i, data[i], pdat[i]);
          end
          run[i]++;
        end else if (pwr[i]) begin
          chk("wr_len", i, 16'(run[i]), 16'(s));
          run[i] = 0;
        end
        pwr[i] = wr[i]; pa0[i] = a0[i]; pdat[i] = data[i];
      end
    end
    if (reset && req_valid[1] && req_ready[1] && acc_n < 2) begin
      acc_t[acc_n] = cyc;
      acc_n++;
    end
  end

  task automatic do_req(input int i, input logic [15:0] c,
                        input logic [15:0] n, input logic w);
    @(posedge clk); #1;
    req_valid[i] = 1'b1; req_ctrl[i] = c;
    req_count[i] = n; req_wait[i] = w;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, output logic to,
                           output logic [15:0] cy);
    bit ok;
    ok = 1'b0; to = 1'bx; cy = 'x;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done_valid[i]) begin
        ok = 1'b1; to = done_timeout[i]; cy = done_cycles[i];
        break;
      end
    end
    chk("done_seen", i, {15'b0, ok}, 16'd1);
  endtask

  logic [6:0]  wrs, css, a0s;
  logic [15:0] d2, d5;
  logic        to_r;
  logic [15:0] cy_r;
  bit          dv_seen;

  initial begin
    reset = 1'b0;
    req_valid = '0; req_wait = '0; timer_out = '0;
    req_ctrl = '0; req_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 0, {15'b0, req_ready[0]}, 16'd1);
    chk("rst_busy", 0, {15'b0, busy[0]}, 16'd0);
    chk("rst_cycles", 0, done_cycles[0], 16'd0);
    chk("rst_timeout", 0, {15'b0, done_timeout[0]}, 16'd0);
    #2 reset = 1'b1;

    // no-wait program, strobe 1
    do_req(0, 16'h0004, 16'h0006, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      wrs[k-1] = wr[0]; css[k-1] = cs[0]; a0s[k-1] = a0[0];
      if (k == 2) d2 = data[0];
      if (k == 5) d5 = data[0];
      if (k == 7) begin
        chk("nw_dv", 0, {15'b0, done_valid[0]}, 16'd1);
        chk("nw_to", 0, {15'b0, done_timeout[0]}, 16'd0);
        chk("nw_cyc", 0, done_cycles[0], 16'd0);
      end
    end
    chk("nw_wr_seq", 0, {9'b0, wrs}, 16'b0010010);
    chk("nw_cs_seq", 0, {9'b0, css}, 16'b0111111);
    chk("nw_a0_seq", 0, {9'b0, a0s}, 16'b0000111);
    chk("nw_data2", 0, d2, 16'h0004);
    chk("nw_data5", 0, d5, 16'h0006);
    @(negedge clk);
    chk("nw_ready_back", 0, {15'b0, req_ready[0]}, 16'd1);

    // edge 20 cycles into wait
    do_req(0, 16'h0012, 16'h0100, 1'b1);
    repeat (26) @(posedge clk);
    #1 timer_out[0] = 1'b1;
    wait_done(0, to_r, cy_r);
    chk("edge_to", 0, {15'b0, to_r}, 16'd0);
    chk("edge_cyc", 0, cy_r, 16'd22);
    timer_out[0] = 1'b0;
    repeat (5) @(posedge clk);

    // level high before wait: no edge, timeout
    #1 timer_out[0] = 1'b1;
    repeat (5) @(posedge clk);
    do_req(0, 16'h0036, 16'h1234, 1'b1);
    wait_done(0, to_r, cy_r);
    chk("lvl_to", 0, {15'b0, to_r}, 16'd1);
    chk("lvl_cyc", 0, cy_r, 16'd50);
    timer_out[0] = 1'b0;
    repeat (5) @(posedge clk);

    // edge coinciding with timeout cycle
    do_req(0, 16'h0030, 16'h0003, 1'b1);
    repeat (53) @(posedge clk);
    #1 timer_out[0] = 1'b1;
    wait_done(0, to_r, cy_r);
    chk("tie_to", 0, {15'b0, to_r}, 16'd0);
    chk("tie_cyc", 0, cy_r, 16'd49);
    timer_out[0] = 1'b0;
    repeat (5) @(posedge clk);

    // back-to-back, strobe 3
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_wait[1] = 1'b0;
    req_ctrl[1] = 16'hAAAA; req_count[1] = 16'h0007;
    @(posedge clk); #1;
    req_ctrl[1] = 16'h5555; req_count[1] = 16'h0009;
    for (int t = 0; t < 40; t++) begin
      if (acc_n >= 2) break;
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b0;
    chk("b2b_accepts", 1, 16'(acc_n), 16'd2);
    if (acc_n >= 2)
      chk("b2b_spacing", 1, 16'(acc_t[1] - acc_t[0]), 16'd12);
    repeat (20) @(posedge clk);

    // reset during control strobe
    do_req(0, 16'h0034, 16'h0002, 1'b0);
    @(posedge clk); #2;
    chk("pre_rst_wr", 0, {15'b0, wr[0]}, 16'd1);
    reset = 1'b0;
    #1;
    chk("rst_cs", 0, {15'b0, cs[0]}, 16'd0);
    chk("rst_wr", 0, {15'b0, wr[0]}, 16'd0);
    chk("rst_a0", 0, {15'b0, a0[0]}, 16'd0);
    chk("rst_data", 0, data[0], 16'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("post_ready", 0, {15'b0, req_ready[0]}, 16'd1);
    chk("post_busy", 0, {15'b0, busy[0]}, 16'd0);
    dv_seen = 1'b0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (done_valid[0]) dv_seen = 1'b1;
    end
    chk("post_no_done", 0, {15'b0, dv_seen}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_bus_master.md
# timer_bus_master

Host-side initiator for the 8253-style TIMER write bus. It accepts a programming request on a valid/ready handshake and issues the two bus writes the TIMER expects: control word with a0=1, then count word with a0=0. It then watches the TIMER `out` line and reports the first rising edge or a timeout, with the elapsed cycle count. It sits between the system sequencer and TIMER, replacing hand-driven cs/wr/a0/data stimulus.

## Interface
- STROBE_CYCLES, 1: wr-high cycles per bus write (1..15).
- TIMEOUT, 1000: max cycles to wait for `out` rising edge after count write (1..65535).
- clk  in  1  rising-edge clock, shared with TIMER.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_ctrl  in  16  control word.
- req_count  in  16  count word.
- req_wait  in  1  1: wait for `out` edge after programming; 0: finish right after count write.
- data  out  16  TIMER data bus.
- cs  out  1  TIMER chip select, active-high.
- wr  out  1  TIMER write strobe, active-high.
- a0  out  1  TIMER register select: 1 control, 0 count.
- timer_out  in  1  TIMER `out`, asynchronous to bus cycles; 2-flop synchronised internally.
- done_valid  out  1  one-cycle completion pulse.
- done_timeout  out  1  valid with done_valid: 1 means the wait expired.
- done_cycles  out  16  valid with done_valid: cycles waited, saturating at 65535.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, C_SETUP, C_STROBE, C_HOLD, N_SETUP, N_STROBE, N_HOLD, WAIT, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, capture ctrl, count and wait, then go to C_SETUP. Requests are ignored in all other states (req_ready=0).
- C_SETUP: cs=1, a0=1, data=ctrl, wr=0. Lasts 1 cycle.
- C_STROBE: cs=1, a0=1, data=ctrl, wr=1. Lasts STROBE_CYCLES cycles.
- C_HOLD: cs=1, a0=1, data=ctrl, wr=0. Lasts 1 cycle.
- N_SETUP, N_STROBE, N_HOLD: same as the C_ states but with a0=0 and data=count.
- After N_HOLD: go to WAIT if the captured wait bit is 1, else to DONE with timeout=0 and cycles=0.
- WAIT: cs=0, wr=0, a0=0, data=0. Cycle counter starts at 0 and increments each cycle.
  - Rising edge on the synchronised timer_out (sync=1, previous=0): go to DONE with timeout=0 and cycles=counter.
  - Counter reaches TIMEOUT-1 with no edge: go to DONE with timeout=1 and cycles=TIMEOUT.
  - Edge and timeout in the same cycle: the edge wins (timeout=0).
  - A level already high on entry to WAIT is not an edge. The edge detector's previous-value register keeps updating in every state.
- DONE: done_valid=1 for 1 cycle, then IDLE.
- Outside the write states: cs=0, wr=0, a0=0, data=0.
- The counter saturates at 65535.

## Timing
- All outputs are registered. Reset values: data=0, cs=0, wr=0, a0=0, req_ready=1, done_valid=0, done_timeout=0, done_cycles=0, busy=0, state=IDLE, sync flops=0.
- Accept in cycle T: C_SETUP outputs appear at T+1 and C_STROBE at T+2.
- Total write phase: 2*(STROBE_CYCLES+2) cycles. With STROBE_CYCLES=1 the strobes (wr=1) land at T+2 and T+5.
- No-wait request: done_valid at T+2*(STROBE_CYCLES+2)+1. req_ready returns 1 in the following cycle.
- Back-to-back: a request held valid during DONE is accepted in the first IDLE cycle. Minimum spacing between accepts is 2*(STROBE_CYCLES+2)+2 cycles.
- a0 and data are stable for the full setup, strobe and hold window. They never change while wr=1.
- timer_out latency: an edge at the pin is seen by the state machine 2 cycles later (plus edge-detect register). done_cycles counts from the first WAIT cycle.
- Reset asserted mid-write: cs, wr, a0 and data drop to 0 asynchronously. The request is lost and no done_valid is issued.

## Test plan
- Reset: assert reset=0 mid-C_STROBE -> cs=wr=0 immediately. After release: req_ready=1, busy=0.
- No-wait program, req_ctrl=16'h0004, req_count=16'h0006, STROBE_CYCLES=1 -> cycle-exact sequence cs=1 a0=1 data=4 with wr 0,1,0, then a0=0 data=6 with wr 0,1,0. done_valid 1 cycle, timeout=0, cycles=0.
- Wait with timer_out rising 20 cycles into WAIT -> done_valid with timeout=0, done_cycles equal to 20 plus synchroniser delay (the bench checks the exact value, 22).
- Wait with timer_out held high from before WAIT, TIMEOUT=50 -> no edge detected. done_timeout=1, done_cycles=50.
- Edge arriving exactly at the timeout cycle -> timeout=0.
- Two requests back-to-back with req_valid held, STROBE_CYCLES=3 -> second accept exactly 12 cycles after the first. wr is high for 3 cycles per write, and a0/data never change while wr=1.
